// File: rtl/updown_sweep_pkg.sv
// Shared definitions for the up/down sweep controller: state encoding and
// default widths.
package updown_sweep_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CYC_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    UP   = ST_UP,
    DOWN = ST_DOWN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/updown_step.sv
// WIDTH-bit count register: load has priority over en; dir=1 steps up,
// dir=0 steps down.
module updown_step #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= dir ? q + WIDTH'(1) : q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Runs a bounded counter through N triangular sweeps lo->hi->lo with a
// start/abort handshake; all outputs come straight from registers.
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [CYC_W-1:0] n_cycles,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CYC_W-1:0] cycles
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [CYC_W-1:0] n_reg;

  logic accept;
  logic reject;
  logic at_hi;
  logic at_lo;
  logic last_sweep;
  logic step_load;
  logic step_en;
  logic step_up;

  assign accept     = (state == IDLE) && start && !abort && (lo < hi);
  assign reject     = (state == IDLE) && start && !abort && !(lo < hi);
  assign at_hi      = (q == hi_reg);
  assign at_lo      = (q == lo_reg);
  assign last_sweep = (n_reg != '0) && (CYC_W'(cycles + CYC_W'(1)) == n_reg);

  // Peak and trough are ordinary +/-1 steps, so only the start needs a load.
  always_comb begin
    state_next = state;
    step_load  = 1'b0;
    step_en    = 1'b0;
    step_up    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = UP;
          step_load  = 1'b1;
        end
      end
      UP: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          step_en = 1'b1;
          step_up = !at_hi;
          if (at_hi) state_next = DOWN;
        end
      end
      DOWN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (at_lo) begin
          if (last_sweep) begin
            state_next = DONE;
          end else begin
            step_en    = 1'b1;
            step_up    = 1'b1;
            state_next = UP;
          end
        end else begin
          step_en = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      lo_reg <= '0;
      hi_reg <= '0;
      n_reg  <= '0;
      cycles <= '0;
      dir    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_next;
      dir   <= (state_next == UP);
      busy  <= (state_next == UP) || (state_next == DOWN);
      done  <= (state_next == DONE);
      err   <= reject;
      if (accept) begin
        lo_reg <= lo;
        hi_reg <= hi;
        n_reg  <= n_cycles;
        cycles <= '0;
      end else if ((state == DOWN) && !abort && at_lo && (cycles != '1)) begin
        // Saturates rather than wrapping when running until abort.
        cycles <= cycles + CYC_W'(1);
      end
    end
  end

  updown_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .clk (clk),
    .rst (reset),
    .load(step_load),
    .en  (step_en),
    .dir (step_up),
    .d   (lo),
    .q   (q)
  );

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl: hand-computed sweep sequences,
// error/abort/reset corner cases, immediate assertions at each check.
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [7:0] n_cycles;
  logic [3:0] q;
  logic       dir;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] cycles;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  updown_sweep_ctrl #(
    .WIDTH(4),
    .CYC_W(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .lo      (lo),
    .hi      (hi),
    .n_cycles(n_cycles),
    .q       (q),
    .dir     (dir),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .cycles  (cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] q_exp2 [13];
    logic       d_exp2 [13];
    logic [3:0] q_exp5 [11];
    int         done_seen;

    q_exp2 = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
    d_exp2 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    q_exp5 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd1, 4'd2, 4'd3, 4'd4, 4'd3};

    // 1: reset held for two clocks with random-looking inputs
    reset    = 1'b1;
    start    = 1'b1;
    abort    = 1'b0;
    lo       = 4'($urandom_range(0, 7));
    hi       = 4'($urandom_range(8, 15));
    n_cycles = 8'($urandom_range(0, 255));
    tick();
    tick();
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_dir", dir, 0);
    chk("rst_cycles", cycles, 0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("idle_q", q, 0);
    chk("idle_busy", busy, 0);
    $display("t1 reset: q=%0d busy=%0b", q, busy);

    // 2: two sweeps 2..5, bounds changed after start must not matter
    lo = 4'd2; hi = 4'd5; n_cycles = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    lo = 4'd0; hi = 4'd15; n_cycles = 8'd0;
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("t2_q[%0d]", i), q, q_exp2[i]);
      chk($sformatf("t2_dir[%0d]", i), dir, d_exp2[i]);
      chk($sformatf("t2_busy[%0d]", i), busy, 1);
      chk($sformatf("t2_done[%0d]", i), done, 0);
      if (i == 6) chk("t2_cycles_mid0", cycles, 0);
      if (i == 7) chk("t2_cycles_mid1", cycles, 1);
      tick();
    end
    chk("t2_done", done, 1);
    chk("t2_done_q", q, 2);
    chk("t2_done_busy", busy, 0);
    chk("t2_cycles", cycles, 2);
    tick();
    chk("t2_idle_done", done, 0);
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_q", q, 2);
    $display("t2 sweep 2..5 x2: q=%0d cycles=%0d", q, cycles);

    // 3: full-range single sweep, no wrap at either end
    lo = 4'd0; hi = 4'd15; n_cycles = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    done_seen = 0;
    for (int i = 0; i <= 30; i++) begin
      chk($sformatf("t3_q[%0d]", i), q, (i <= 15) ? i : 30 - i);
      if (done) done_seen++;
      tick();
    end
    chk("t3_no_early_done", done_seen, 0);
    chk("t3_done", done, 1);
    chk("t3_done_q", q, 0);
    chk("t3_cycles", cycles, 1);
    tick();
    chk("t3_done_once", done, 0);
    $display("t3 sweep 0..15: q=%0d cycles=%0d", q, cycles);

    // 4: lo >= hi rejected with a single err pulse
    lo = 4'd7; hi = 4'd7; n_cycles = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_q", q, 0);
    tick();
    chk("t4_err_pulse", err, 0);
    chk("t4_busy2", busy, 0);
    lo = 4'd9; hi = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_err_inv", err, 1);
    chk("t4_cycles_kept", cycles, 1);
    tick();
    $display("t4 rejects: err=%0b busy=%0b", err, busy);

    // 5: endless sweep 1..4, start ignored while busy, abort on descent at q=3
    lo = 4'd1; hi = 4'd4; n_cycles = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("t5_q[%0d]", i), q, q_exp5[i]);
      chk($sformatf("t5_err[%0d]", i), err, 0);
      start = (i >= 2 && i <= 4);
      lo = 4'd0; hi = 4'd9;
      if (i == 10) abort = 1'b1;
      if (i < 10) tick();
    end
    chk("t5_cycles_pre", cycles, 1);
    tick();
    abort = 1'b0;
    chk("t5_abort_q", q, 3);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_done", done, 0);
    chk("t5_abort_cycles", cycles, 1);
    tick();
    chk("t5_hold_q", q, 3);
    chk("t5_hold_done", done, 0);
    chk("t5_hold_busy", busy, 0);
    $display("t5 abort: q=%0d cycles=%0d", q, cycles);

    // 6: start+abort together ignored; async reset mid-UP
    lo = 4'd2; hi = 4'd6; n_cycles = 8'd1; start = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_sa_busy", busy, 0);
    chk("t6_sa_q", q, 3);
    chk("t6_sa_err", err, 0);
    tick();
    start = 1'b0;
    chk("t6_start_q", q, 2);
    chk("t6_start_busy", busy, 1);
    tick();
    tick();
    chk("t6_up_q", q, 4);
    chk("t6_up_dir", dir, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_q", q, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_dir", dir, 0);
    reset = 1'b0;
    tick();
    chk("t6_after_q", q, 0);
    chk("t6_after_busy", busy, 0);
    $display("t6 async reset: q=%0d busy=%0b", q, busy);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
